// File: rtl/host_csr_pkg.sv
// Shared register map, word-index constants and FSM state types for host_csr.
package host_csr_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = ADDR_W - 2;

  localparam logic [ADDR_W-1:0] CTRL_OFF     = 16'h0000;
  localparam logic [ADDR_W-1:0] ECNT_OFF     = 16'h0004;
  localparam logic [ADDR_W-1:0] PTR_BASE_OFF = 16'h0008;

  localparam logic [IDX_W-1:0] CTRL_IDX     = CTRL_OFF[ADDR_W-1:2];
  localparam logic [IDX_W-1:0] ECNT_IDX     = ECNT_OFF[ADDR_W-1:2];
  localparam logic [IDX_W-1:0] PTR_BASE_IDX = PTR_BASE_OFF[ADDR_W-1:2];

  localparam logic [DATA_W-1:0] ECNT_MAX = '1;

  typedef enum logic [1:0] {
    W_ADDR,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_ADDR,
    R_DATA
  } r_state_e;

  // Byte address to register word index; the two low address bits are don't-care.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/host_csr.sv
// AXI-lite host control/status block: launch/finish handshake, cycle counter
// and NUM_PTR pointer registers, with independent read and write channels.
module host_csr
  import host_csr_pkg::*;
#(
  parameter int unsigned NUM_PTR = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      host_aw_valid,
  output logic                      host_aw_ready,
  input  logic [ADDR_W-1:0]         host_aw_bits_addr,
  input  logic                      host_w_valid,
  output logic                      host_w_ready,
  input  logic [DATA_W-1:0]         host_w_bits_data,
  output logic                      host_b_valid,
  input  logic                      host_b_ready,
  input  logic                      host_ar_valid,
  output logic                      host_ar_ready,
  input  logic [ADDR_W-1:0]         host_ar_bits_addr,
  output logic                      host_r_valid,
  input  logic                      host_r_ready,
  output logic [DATA_W-1:0]         host_r_bits_data,
  output logic                      launch,
  input  logic                      finish,
  output logic [DATA_W*NUM_PTR-1:0] ptrs
);

  w_state_e          w_state_q;
  r_state_e          r_state_q;
  logic [IDX_W-1:0]  waddr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              launch_q;
  logic              finish_q;
  logic [DATA_W-1:0] ecnt_q;
  logic [DATA_W-1:0] ptr_q [NUM_PTR];

  logic              aw_fire_c;
  logic              w_fire_c;
  logic              ar_fire_c;
  logic              wr_ctrl_c;
  logic [IDX_W-1:0]  ar_idx_c;
  logic [DATA_W-1:0] rd_mux_c;
  logic              unused_addr_lsb;

  // Handshake outputs decode straight from state and are forced low during reset.
  assign host_aw_ready    = !reset && (w_state_q == W_ADDR);
  assign host_w_ready     = !reset && (w_state_q == W_DATA);
  assign host_b_valid     = !reset && (w_state_q == W_RESP);
  assign host_ar_ready    = !reset && (r_state_q == R_ADDR);
  assign host_r_valid     = !reset && (r_state_q == R_DATA);
  assign host_r_bits_data = reset ? '0 : rdata_q;
  assign launch           = launch_q;

  assign aw_fire_c       = host_aw_valid && host_aw_ready;
  assign w_fire_c        = host_w_valid && host_w_ready;
  assign ar_fire_c       = host_ar_valid && host_ar_ready;
  assign wr_ctrl_c       = w_fire_c && (waddr_q == CTRL_IDX);
  assign ar_idx_c        = word_idx(host_ar_bits_addr);
  assign unused_addr_lsb = ^{host_aw_bits_addr[1:0], host_ar_bits_addr[1:0]};

  for (genvar g = 0; g < NUM_PTR; g++) begin : g_ptrs
    assign ptrs[DATA_W*g +: DATA_W] = ptr_q[g];
  end

  // Read data select from current register values, so a same-cycle write is not visible.
  always_comb begin
    rd_mux_c = '0;
    if (ar_idx_c == CTRL_IDX) begin
      rd_mux_c = {(DATA_W-2)'(0), finish_q, launch_q};
    end else if (ar_idx_c == ECNT_IDX) begin
      rd_mux_c = ecnt_q;
    end else begin
      for (int k = 0; k < NUM_PTR; k++) begin
        if (ar_idx_c == PTR_BASE_IDX + IDX_W'(k)) rd_mux_c = ptr_q[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q <= W_ADDR;
      waddr_q   <= '0;
    end else begin
      case (w_state_q)
        W_ADDR: if (aw_fire_c) begin
          waddr_q   <= word_idx(host_aw_bits_addr);
          w_state_q <= W_DATA;
        end
        W_DATA: if (w_fire_c) w_state_q <= W_RESP;
        W_RESP: if (host_b_ready) w_state_q <= W_ADDR;
        default: w_state_q <= W_ADDR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_ADDR;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_ADDR: if (ar_fire_c) begin
          rdata_q   <= rd_mux_c;
          r_state_q <= R_DATA;
        end
        R_DATA: if (host_r_ready) r_state_q <= R_ADDR;
        default: r_state_q <= R_ADDR;
      endcase
    end
  end

  // A CTRL write overrides a coincident finish pulse; a launching write also restarts ECNT.
  always_ff @(posedge clock) begin
    if (reset) begin
      launch_q <= 1'b0;
      finish_q <= 1'b0;
      ecnt_q   <= '0;
      for (int k = 0; k < NUM_PTR; k++) ptr_q[k] <= '0;
    end else begin
      if (launch_q && !finish_q && (ecnt_q != ECNT_MAX)) ecnt_q <= ecnt_q + DATA_W'(1);
      if (wr_ctrl_c) begin
        launch_q <= host_w_bits_data[0];
        if (host_w_bits_data[0]) begin
          finish_q <= 1'b0;
          ecnt_q   <= '0;
        end
      end else if (finish && launch_q) begin
        finish_q <= 1'b1;
        launch_q <= 1'b0;
      end
      for (int k = 0; k < NUM_PTR; k++) begin
        if (w_fire_c && (waddr_q == PTR_BASE_IDX + IDX_W'(k))) ptr_q[k] <= host_w_bits_data;
      end
    end
  end

endmodule

// File: tb/tb_host_csr.sv
// Directed plus randomized bench for host_csr against a cycle-level register-map model.
module tb_host_csr;
  import host_csr_pkg::*;

  localparam int unsigned NP = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              host_aw_valid = 1'b0;
  logic              host_aw_ready;
  logic [15:0]       host_aw_bits_addr = '0;
  logic              host_w_valid = 1'b0;
  logic              host_w_ready;
  logic [31:0]       host_w_bits_data = '0;
  logic              host_b_valid;
  logic              host_b_ready = 1'b0;
  logic              host_ar_valid = 1'b0;
  logic              host_ar_ready;
  logic [15:0]       host_ar_bits_addr = '0;
  logic              host_r_valid;
  logic              host_r_ready = 1'b0;
  logic [31:0]       host_r_bits_data;
  logic              launch;
  logic              finish = 1'b0;
  logic [32*NP-1:0]  ptrs;

  always #5 clock = ~clock;

  host_csr #(.NUM_PTR(NP)) dut (
    .clock(clock), .reset(reset),
    .host_aw_valid(host_aw_valid), .host_aw_ready(host_aw_ready), .host_aw_bits_addr(host_aw_bits_addr),
    .host_w_valid(host_w_valid), .host_w_ready(host_w_ready), .host_w_bits_data(host_w_bits_data),
    .host_b_valid(host_b_valid), .host_b_ready(host_b_ready),
    .host_ar_valid(host_ar_valid), .host_ar_ready(host_ar_ready), .host_ar_bits_addr(host_ar_bits_addr),
    .host_r_valid(host_r_valid), .host_r_ready(host_r_ready), .host_r_bits_data(host_r_bits_data),
    .launch(launch), .finish(finish), .ptrs(ptrs)
  );

  // Reference model: register contents plus the channel phase each handshake is in.
  logic        m_launch, m_finish;
  logic [31:0] m_ecnt;
  logic [31:0] m_ptr [NP];
  logic [15:0] m_waddr;
  logic [31:0] m_rdata;
  int          m_wph, m_rph;
  bit          f_aw, f_w, f_b, f_ar, f_r;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_read(input logic [15:0] a);
    int idx;
    idx = int'(a >> 2);
    if (idx == 0) return {30'd0, m_finish, m_launch};
    if (idx == 1) return m_ecnt;
    if (idx >= 2 && idx < 2 + NP) return m_ptr[idx-2];
    return 32'd0;
  endfunction

  function automatic logic [127:0] m_ptrs();
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < NP; k++) v[32*k +: 32] = m_ptr[k];
    return v;
  endfunction

  task automatic model_reset();
    m_launch = 0; m_finish = 0; m_ecnt = 0; m_waddr = 0; m_rdata = 0;
    for (int k = 0; k < NP; k++) m_ptr[k] = 0;
    m_wph = 0; m_rph = 0;
    f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0;
  endtask

  task automatic check_outputs();
    check("aw_ready", host_aw_ready, !reset && m_wph == 0);
    check("w_ready", host_w_ready, !reset && m_wph == 1);
    check("b_valid", host_b_valid, !reset && m_wph == 2);
    check("ar_ready", host_ar_ready, !reset && m_rph == 0);
    check("r_valid", host_r_valid, !reset && m_rph == 1);
    if (reset) check("r_data_rst", host_r_bits_data, 0);
    else if (m_rph == 1) check("r_data", host_r_bits_data, m_rdata);
    check("launch", launch, m_launch);
    check("ptrs", ptrs, m_ptrs());
  endtask

  // One clock: apply the register-map rules to what the bench drove, then compare.
  task automatic tick();
    bit          aw_f, w_f, b_f, ar_f, r_f, ctrl_wr, fin;
    logic [31:0] rd, wd;
    logic [15:0] aw_a;
    int          idx;
    aw_f = (m_wph == 0) && host_aw_valid;
    w_f  = (m_wph == 1) && host_w_valid;
    b_f  = (m_wph == 2) && host_b_ready;
    ar_f = (m_rph == 0) && host_ar_valid;
    r_f  = (m_rph == 1) && host_r_ready;
    rd   = m_read(host_ar_bits_addr);
    wd   = host_w_bits_data;
    aw_a = host_aw_bits_addr;
    fin  = finish;
    @(posedge clock);
    if (reset) begin
      model_reset();
    end else begin
      if (ar_f) m_rdata = rd;
      if (m_launch && !m_finish && m_ecnt != 32'hFFFF_FFFF) m_ecnt = m_ecnt + 1;
      idx = int'(m_waddr >> 2);
      ctrl_wr = w_f && idx == 0;
      if (w_f) begin
        if (idx == 0) begin
          m_launch = wd[0];
          if (wd[0]) begin m_finish = 0; m_ecnt = 0; end
        end else if (idx >= 2 && idx < 2 + NP) begin
          m_ptr[idx-2] = wd;
        end
      end
      if (!ctrl_wr && fin && m_launch) begin m_finish = 1; m_launch = 0; end
      if (aw_f) m_waddr = aw_a;
      if (aw_f) m_wph = 1; else if (w_f) m_wph = 2; else if (b_f) m_wph = 0;
      if (ar_f) m_rph = 1; else if (r_f) m_rph = 0;
      f_aw = aw_f; f_w = w_f; f_b = b_f; f_ar = ar_f; f_r = r_f;
    end
    #1;
    if (f_aw) host_aw_valid = 0;
    if (f_w)  host_w_valid = 0;
    if (f_ar) host_ar_valid = 0;
    finish = 0;
    check_outputs();
  endtask

  task automatic write_txn(input logic [15:0] a, input logic [31:0] d, input bit fin_with_w);
    int n;
    host_aw_valid = 1; host_aw_bits_addr = a;
    n = 0; do begin tick(); n++; end while (!f_aw && n < 16);
    if (!f_aw) check("aw_timeout", f_aw, 1);
    host_w_valid = 1; host_w_bits_data = d; host_b_ready = 1;
    if (fin_with_w) finish = 1;
    n = 0; do begin tick(); n++; end while (!f_w && n < 16);
    if (!f_w) check("w_timeout", f_w, 1);
    n = 0; do begin tick(); n++; end while (!f_b && n < 16);
    if (!f_b) check("b_timeout", f_b, 1);
    host_b_ready = 0;
  endtask

  task automatic read_txn(input logic [15:0] a, output logic [31:0] d);
    int n;
    host_ar_valid = 1; host_ar_bits_addr = a;
    n = 0; do begin tick(); n++; end while (!f_ar && n < 16);
    if (!f_ar) check("ar_timeout", f_ar, 1);
    d = host_r_bits_data;
    host_r_ready = 1;
    n = 0; do begin tick(); n++; end while (!f_r && n < 16);
    if (!f_r) check("r_timeout", f_r, 1);
    host_r_ready = 0;
  endtask

  function automatic logic [15:0] rnd_addr();
    int unsigned pick;
    pick = $urandom_range(0, 8);
    if (pick <= 5) return 16'(pick * 4) | 16'($urandom_range(0, 3));
    if (pick == 6) return 16'h0040;
    return 16'($urandom);
  endfunction

  initial begin
    logic [31:0] d;
    model_reset();
    repeat (3) tick();
    reset = 0;
    #1;
    check("aw_ready_after_rst", host_aw_ready, 1);
    check("ar_ready_after_rst", host_ar_ready, 1);

    // PTR1 write/readback, including an unaligned read address
    write_txn(16'h000C, 32'hDEADBEEF, 0);
    read_txn(16'h000C, d);
    check("ptr1_read", d, 32'hDEADBEEF);
    check("ptrs_63_32", ptrs[63:32], 32'hDEADBEEF);
    read_txn(16'h000E, d);
    check("ptr1_read_unaligned", d, 32'hDEADBEEF);

    // launch, run, finish, then inspect CTRL and ECNT
    write_txn(16'h0000, 32'h1, 0);
    repeat (10) tick();
    finish = 1;
    tick();
    read_txn(16'h0000, d);
    check("ctrl_after_finish", d, 32'h2);
    check("launch_after_finish", launch, 0);
    read_txn(16'h0004, d);
    check("ecnt_after_finish", d, m_rdata);
    check("ecnt_held", d > 32'd0, 1);

    // CTRL write wins over a coincident finish pulse
    write_txn(16'h0000, 32'h1, 0);
    write_txn(16'h0000, 32'h1, 1);
    check("launch_ctrl_wins", launch, 1);
    read_txn(16'h0000, d);
    check("ctrl_ctrl_wins", d, 32'h1);
    read_txn(16'h0004, d);
    check("ecnt_ctrl_wins", d, m_rdata);
    finish = 1;
    tick();
    check("launch_stopped", launch, 0);

    // unmapped read and write
    read_txn(16'h0040, d);
    check("unmapped_read", d, 32'h0);
    write_txn(16'h0040, 32'h1234, 0);
    check("ptrs_after_unmapped", ptrs, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});

    // B held off for 5 cycles while a PTR0 read runs alongside
    host_aw_valid = 1; host_aw_bits_addr = 16'h0008;
    tick();
    host_w_valid = 1; host_w_bits_data = 32'hA5A5_0F0F; host_b_ready = 0;
    tick();
    host_ar_valid = 1; host_ar_bits_addr = 16'h0008;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b_valid_held", host_b_valid, 1);
      if (i == 0) begin
        check("ptr0_concurrent_read", host_r_bits_data, 32'hA5A5_0F0F);
        host_r_ready = 1;
      end
    end
    host_r_ready = 0;
    check("read_done_while_b", host_ar_ready, 1);
    host_b_ready = 1;
    tick();
    host_b_ready = 0;

    // read and write of PTR2 in the same cycle returns the old value
    host_aw_valid = 1; host_aw_bits_addr = 16'h0010;
    tick();
    host_w_valid = 1; host_w_bits_data = 32'h5555_AAAA;
    host_ar_valid = 1; host_ar_bits_addr = 16'h0010;
    tick();
    check("same_cycle_rd_old", host_r_bits_data, 32'h0);
    host_r_ready = 1; host_b_ready = 1;
    tick();
    host_r_ready = 0; host_b_ready = 0;
    read_txn(16'h0010, d);
    check("ptr2_new", d, 32'h5555_AAAA);

    // reset during W_DATA abandons the write
    host_aw_valid = 1; host_aw_bits_addr = 16'h0014;
    tick();
    host_w_valid = 1; host_w_bits_data = 32'h77; reset = 1;
    tick();
    reset = 0; host_w_valid = 0;
    #1;
    check("aw_ready_post_abort", host_aw_ready, 1);
    check("ptrs_post_abort", ptrs, 128'h0);
    write_txn(16'h0014, 32'h77, 0);
    check("ptr3_new_write", ptrs[127:96], 32'h77);

    // randomized traffic, valid held until accepted
    for (int c = 0; c < 600; c++) begin
      if (!host_aw_valid && $urandom_range(0, 2) == 0) begin
        host_aw_valid = 1; host_aw_bits_addr = rnd_addr();
      end
      if (!host_w_valid && $urandom_range(0, 2) == 0) begin
        host_w_valid = 1; host_w_bits_data = $urandom;
      end
      if (!host_ar_valid && $urandom_range(0, 1) == 0) begin
        host_ar_valid = 1; host_ar_bits_addr = rnd_addr();
      end
      host_b_ready = 1'($urandom_range(0, 1));
      host_r_ready = 1'($urandom_range(0, 1));
      finish = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
